// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin share of one memory port among REQ_CNT requesters.
// Latency: request granted combinationally in the cycle it is presented; read data returns next cycle.
// Backpressure: req_ready is one-hot on the winner only; responses cannot be stalled.
//
// Optional feature macro: MEM_ARB_BURST_EN lets the current owner hold the grant for up to
// BURST_LEN consecutive transfers. When it is undefined the grant rotates after every transfer.
//
// Ports:
//   clk, n_rst                    clock (shared with the memory port), async active-low reset
//   req_valid/req_ready           per-requester request handshake
//   req_write/req_addr/req_wdata  per-requester command, packed at [i*W +: W]
//   rsp_valid/rsp_data            one-hot read-response strobe and shared read data bus
//   mem_addr/mem_data_in/mem_write_en/mem_data_out   memory port connection
module mem_port_arbiter #(
  parameter int REQ_CNT    = 4,
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 14,
  parameter int BURST_LEN  = 4
) (
  input  logic                             clk,
  input  logic                             n_rst,
  input  logic [REQ_CNT-1:0]               req_valid,
  output logic [REQ_CNT-1:0]               req_ready,
  input  logic [REQ_CNT-1:0]               req_write,
  input  logic [REQ_CNT*ADDR_WIDTH-1:0]    req_addr,
  input  logic [REQ_CNT*DATA_WIDTH-1:0]    req_wdata,
  output logic [REQ_CNT-1:0]               rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_data,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [DATA_WIDTH-1:0]            mem_data_in,
  output logic                             mem_write_en,
  input  logic [DATA_WIDTH-1:0]            mem_data_out
);

  localparam int LGW = (REQ_CNT > 1) ? $clog2(REQ_CNT) : 1;

  if (REQ_CNT < 2 || REQ_CNT > 8) begin : g_bad_req_cnt
    $error("mem_port_arbiter: REQ_CNT must be in 2..8");
  end
  if (BURST_LEN < 1) begin : g_bad_burst_len
    $error("mem_port_arbiter: BURST_LEN must be at least 1");
  end

  logic [LGW-1:0]        last_grant;
  logic [LGW-1:0]        rr_winner;
  logic [LGW-1:0]        cand;
  logic [LGW-1:0]        sel;
  logic                  any_vld;
  logic                  xfer;
  logic [REQ_CNT-1:0]    grant;
  logic [REQ_CNT-1:0]    rsp_sel;
  logic                  rsp_pending;
  logic [ADDR_WIDTH-1:0] addr_q;

  // Unpacked views of the packed per-requester buses so they can be indexed by the winner.
  logic [ADDR_WIDTH-1:0] addr_arr  [REQ_CNT];
  logic [DATA_WIDTH-1:0] wdata_arr [REQ_CNT];

  for (genvar i = 0; i < REQ_CNT; i++) begin : g_unpack
    assign addr_arr[i]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Round-robin search starting one past the previous winner, wrapping around.
  always_comb begin
    any_vld   = 1'b0;
    rr_winner = last_grant;
    cand      = '0;
    for (int k = 1; k <= REQ_CNT; k++) begin
      cand = LGW'((int'(last_grant) + k) % REQ_CNT);
      if (!any_vld && req_valid[cand]) begin
        any_vld   = 1'b1;
        rr_winner = cand;
      end
    end
  end

`ifdef MEM_ARB_BURST_EN
  localparam int BCW = $clog2(BURST_LEN) + 1;

  logic [BCW-1:0] burst_cnt;
  logic           keep;

  // The owner keeps the port only while it is still requesting, has transferred in the
  // previous cycle (counter non-zero) and has not used up its burst allowance.
  assign keep = (burst_cnt != '0) && (burst_cnt < BCW'(BURST_LEN)) && req_valid[last_grant];
  assign sel  = keep ? last_grant : rr_winner;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      burst_cnt <= '0;
    end else if (!xfer) begin
      burst_cnt <= '0;
    end else if (keep) begin
      burst_cnt <= burst_cnt + 1'b1;
    end else begin
      burst_cnt <= BCW'(1);
    end
  end
`else
  assign sel = rr_winner;
`endif

  // Reset forces the port idle even if requesters are already asserting valid.
  assign xfer = any_vld && n_rst;

  always_comb begin
    grant = '0;
    if (xfer) begin
      grant[sel] = 1'b1;
    end
  end

  assign req_ready    = grant;
  assign mem_write_en = xfer && req_write[sel];
  // With no transfer the address holds, so the memory keeps presenting the same word.
  assign mem_addr     = xfer ? addr_arr[sel] : addr_q;
  assign mem_data_in  = xfer ? wdata_arr[sel] : '0;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      last_grant  <= LGW'(REQ_CNT - 1);
      addr_q      <= '0;
      rsp_sel     <= '0;
      rsp_pending <= 1'b0;
    end else begin
      addr_q      <= mem_addr;
      rsp_pending <= xfer && !req_write[sel];
      rsp_sel     <= mem_write_en ? '0 : grant;
      if (xfer) begin
        last_grant <= sel;
      end
    end
  end

  // The memory registers the address on the same edge the read is accepted, so its output
  // during the following cycle is the requested word and can be passed straight through.
  assign rsp_valid = rsp_pending ? rsp_sel : '0;
  assign rsp_data  = mem_data_out;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed test of mem_port_arbiter against a behavioural 64x14 memory.
// Latency: inputs change 1 time unit after posedge; outputs sampled at negedge.
// Backpressure: none modelled; requesters simply hold valid until they choose to drop it.
module tb_mem_port_arbiter;

  localparam int RC = 4;
  localparam int AW = 6;
  localparam int DW = 14;

  logic              clk = 1'b0;
  logic              n_rst;
  logic [RC-1:0]     req_valid;
  logic [RC-1:0]     req_ready;
  logic [RC-1:0]     req_write;
  logic [RC*AW-1:0]  req_addr;
  logic [RC*DW-1:0]  req_wdata;
  logic [RC-1:0]     rsp_valid;
  logic [DW-1:0]     rsp_data;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_data_in;
  logic              mem_write_en;
  logic [DW-1:0]     mem_data_out;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .REQ_CNT(RC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(4)
  ) dut (
    .clk(clk), .n_rst(n_rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_write_en(mem_write_en),
    .mem_data_out(mem_data_out)
  );

  // Behavioural memory: registered address, combinational read of mem[addr_reg].
  // The first edge preloads word a with 0x1000 + a.
  logic [DW-1:0] mem [64];
  logic [AW-1:0] addr_reg = '0;
  logic          init_done = 1'b0;

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 64; i++) mem[i] <= 14'h1000 + 14'(i);
      init_done <= 1'b1;
    end else if (mem_write_en) begin
      mem[mem_addr] <= mem_data_in;
    end
    addr_reg <= mem_addr;
  end
  assign mem_data_out = init_done ? mem[addr_reg] : '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]          = v;
    req_write[i]          = w;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic idle_all();
    req_valid = '0;
    req_write = '0;
  endtask

  task automatic do_reset();
    idle_all();
    n_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e;
    int p;
    n_rst     = 1'b0;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;

    // Reset / idle: requests during reset must not be granted.
    repeat (5) @(posedge clk);
    #1;
    req_valid = 4'hF;
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_we", 32'(mem_write_en), 32'h0);
    check("rst_rsp", 32'(rsp_valid), 32'h0);
    check("rst_addr", 32'(mem_addr), 32'h0);
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    req_valid = '0;
    @(negedge clk);
    check("idle_ready", 32'(req_ready), 32'h0);
    check("idle_we", 32'(mem_write_en), 32'h0);
    check("idle_rsp", 32'(rsp_valid), 32'h0);

    // Requester 2 writes addr 5 = 0x101, then reads it back.
    step();
    set_req(2, 1'b1, 1'b1, 6'd5, 14'h101);
    @(negedge clk);
    check("wr_ready", 32'(req_ready), 32'h4);
    check("wr_we", 32'(mem_write_en), 32'h1);
    check("wr_addr", 32'(mem_addr), 32'd5);
    check("wr_data", 32'(mem_data_in), 32'h101);
    step();
    set_req(2, 1'b1, 1'b0, 6'd5, 14'h0);
    @(negedge clk);
    check("rd_ready", 32'(req_ready), 32'h4);
    check("rd_we", 32'(mem_write_en), 32'h0);
    check("rd_rsp_early", 32'(rsp_valid), 32'h0);
    step();
    idle_all();
    @(negedge clk);
    check("rd_rsp", 32'(rsp_valid), 32'h4);
    check("rd_data", 32'(rsp_data), 32'h101);
    check("hold_addr", 32'(mem_addr), 32'd5);
    check("hold_ready", 32'(req_ready), 32'h0);
    step();
    @(negedge clk);
    check("no_rsp_after", 32'(rsp_valid), 32'h0);

    // Round-robin: all four read addr 8+i continuously from a fresh reset.
    do_reset();
    for (int i = 0; i < RC; i++) set_req(i, 1'b1, 1'b0, 6'(8 + i), 14'h0);
    p = 0;
    for (int k = 0; k < 8; k++) begin
`ifdef MEM_ARB_BURST_EN
      e = (k / 4) % RC;
`else
      e = k % RC;
`endif
      @(negedge clk);
      check($sformatf("rr_ready%0d", k), 32'(req_ready), 32'(1 << e));
      check($sformatf("rr_addr%0d", k), 32'(mem_addr), 32'(8 + e));
      if (k > 0) begin
        check($sformatf("rr_rsp%0d", k), 32'(rsp_valid), 32'(1 << p));
        check($sformatf("rr_data%0d", k), 32'(rsp_data), 32'h1000 + 32'(8 + p));
      end
      p = e;
      step();
    end
    idle_all();
    @(negedge clk);
    check("rr_rsp_last", 32'(rsp_valid), 32'(1 << p));
    check("rr_data_last", 32'(rsp_data), 32'h1000 + 32'(8 + p));

    // Write-then-read hazard on addr 16.
    step();
    set_req(0, 1'b1, 1'b1, 6'd16, 14'h200);
    @(negedge clk);
    check("hz_wr_ready", 32'(req_ready), 32'h1);
    check("hz_wr_we", 32'(mem_write_en), 32'h1);
    step();
    set_req(0, 1'b0, 1'b0, 6'd0, 14'h0);
    set_req(1, 1'b1, 1'b0, 6'd16, 14'h0);
    @(negedge clk);
    check("hz_rd_ready", 32'(req_ready), 32'h2);
    step();
    idle_all();
    @(negedge clk);
    check("hz_rsp", 32'(rsp_valid), 32'h2);
    check("hz_data", 32'(rsp_data), 32'h200);

    // A lone requester wins again after wrapping all the way around.
    step();
    set_req(0, 1'b1, 1'b0, 6'd3, 14'h0);
    @(negedge clk);
    check("wrap_ready0", 32'(req_ready), 32'h1);
    step();
    @(negedge clk);
    check("wrap_ready1", 32'(req_ready), 32'h1);
    check("wrap_rsp", 32'(rsp_valid), 32'h1);
    check("wrap_data", 32'(rsp_data), 32'h1003);
    step();
    idle_all();

    // Reset asserted before the edge that would accept requester 3's read.
    set_req(3, 1'b1, 1'b0, 6'd20, 14'h0);
    @(negedge clk);
    check("mr_ready", 32'(req_ready), 32'h8);
    #2;
    n_rst = 1'b0;
    idle_all();
    @(negedge clk);
    check("mr_rsp_rst", 32'(rsp_valid), 32'h0);
    check("mr_ready_rst", 32'(req_ready), 32'h0);
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    for (int i = 0; i < RC; i++) set_req(i, 1'b1, 1'b0, 6'(i), 14'h0);
    @(negedge clk);
    check("mr_rsp_after", 32'(rsp_valid), 32'h0);
    check("mr_first_win", 32'(req_ready), 32'h1);
    step();
    idle_all();

`ifdef MEM_ARB_BURST_EN
    // Owner dropping valid mid-burst hands over immediately.
    do_reset();
    set_req(0, 1'b1, 1'b0, 6'd1, 14'h0);
    set_req(1, 1'b1, 1'b0, 6'd2, 14'h0);
    @(negedge clk);
    check("bu_g0", 32'(req_ready), 32'h1);
    step();
    @(negedge clk);
    check("bu_g1", 32'(req_ready), 32'h1);
    step();
    set_req(0, 1'b0, 1'b0, 6'd1, 14'h0);
    @(negedge clk);
    check("bu_drop", 32'(req_ready), 32'h2);
    step();
    idle_all();
`endif

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
